// File: rtl/ram_arb_ctrl_pkg.sv
// ram_arb_pkg: shared types and constants for the two-port RAM arbiter controller.
package ram_arb_pkg;
    localparam int NUM_PORTS = 2;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    typedef logic port_id_t;
endpackage

// File: rtl/ram_arb_ctrl_if.sv
// ram_arb_ctrl_if: request/response bus of both masters plus the RAM port.
interface ram_arb_ctrl_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) ();
    import ram_arb_pkg::*;
    logic [NUM_PORTS-1:0]        req_valid;
    logic [NUM_PORTS-1:0]        req_ready;
    logic [NUM_PORTS-1:0]        req_wr;
    logic [NUM_PORTS*ADDR_W-1:0] req_addr;
    logic [NUM_PORTS*DATA_W-1:0] req_wdata;
    logic [NUM_PORTS-1:0]        rsp_valid;
    logic [DATA_W-1:0]           rsp_rdata;
    logic                        ram_cs;
    logic                        ram_wr;
    logic                        ram_rd;
    logic [ADDR_W-1:0]           ram_addr;
    logic [DATA_W-1:0]           ram_wdata;
    logic [DATA_W-1:0]           ram_rdata;
    modport slave (
        input  req_valid, req_wr, req_addr, req_wdata, ram_rdata,
        output req_ready, rsp_valid, rsp_rdata, ram_cs, ram_wr, ram_rd, ram_addr, ram_wdata
    );
    modport master (
        output req_valid, req_wr, req_addr, req_wdata, ram_rdata,
        input  req_ready, rsp_valid, rsp_rdata, ram_cs, ram_wr, ram_rd, ram_addr, ram_wdata
    );
endinterface

// File: rtl/ram_arb_ctrl_arbiter.sv
// ram_rr_arbiter: two-way round-robin grant with last-winner register.
module ram_rr_arbiter
    import ram_arb_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en_i,
    input  logic                 upd_i,
    input  logic [NUM_PORTS-1:0] valid_i,
    output port_id_t             gnt_o,
    output logic [NUM_PORTS-1:0] ready_o
);
    port_id_t last_gnt_q, last_gnt_d;

    // Under contention the port that did not win last time goes first.
    assign gnt_o      = (valid_i == 2'b11) ? ~last_gnt_q : valid_i[1];
    assign ready_o    = (en_i && |valid_i) ? {gnt_o, ~gnt_o} : 2'b00;
    assign last_gnt_d = upd_i ? gnt_o : last_gnt_q;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) last_gnt_q <= 1'b1;
        else        last_gnt_q <= last_gnt_d;
endmodule

// File: rtl/ram_arb_ctrl.sv
// ram_arb_ctrl: shares one single-port synchronous RAM between two masters,
// one RAM cycle per accepted request, read data returned with a one-cycle pulse.
module ram_arb_ctrl
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    ram_arb_ctrl_if.slave   bus
);
    localparam int CW = $clog2(RD_LAT + 1);

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                wr_q, wr_d;
    port_id_t            port_q, port_d;
    port_id_t            gnt;
    logic [NUM_PORTS-1:0] ready;
    logic                hs;

    // Ready is forced low while reset is held so every output reads 0.
    ram_rr_arbiter u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_i    ((state_q == IDLE) && rst_n),
        .upd_i   (hs),
        .valid_i (bus.req_valid),
        .gnt_o   (gnt),
        .ready_o (ready)
    );

    assign hs      = |(bus.req_valid & ready);
    assign addr_d  = hs ? bus.req_addr[gnt*ADDR_W +: ADDR_W] : addr_q;
    assign wdata_d = hs ? bus.req_wdata[gnt*DATA_W +: DATA_W] : wdata_q;
    assign wr_d    = hs ? bus.req_wr[gnt] : wr_q;
    assign port_d  = hs ? gnt : port_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE:  state_d = hs ? ISSUE : IDLE;
            ISSUE: begin
                state_d = wr_q ? IDLE : WAIT;
                cnt_d   = wr_q ? cnt_q : CW'(RD_LAT);
            end
            WAIT: begin
                cnt_d   = cnt_q - CW'(1);
                state_d = (cnt_q == CW'(1)) ? RESP : WAIT;
                rdata_d = (cnt_q == CW'(1)) ? bus.ram_rdata : rdata_q;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            wr_q    <= 1'b0;
            port_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            wr_q    <= wr_d;
            port_q  <= port_d;
        end

    assign bus.req_ready = ready;
    assign bus.ram_cs    = (state_q == ISSUE);
    assign bus.ram_wr    = (state_q == ISSUE) && wr_q;
    assign bus.ram_rd    = (state_q == ISSUE) && !wr_q;
    assign bus.ram_addr  = addr_q;
    assign bus.ram_wdata = wdata_q;
    assign bus.rsp_valid = (state_q == RESP) ? {port_q, ~port_q} : 2'b00;
    assign bus.rsp_rdata = rdata_q;
endmodule

// File: tb/tb_ram_arb_ctrl.sv
// tb_ram_arb_ctrl: directed checks of the RAM arbiter controller at RD_LAT 1 and 3.
module tb_ram_arb_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ram_arb_ctrl_if #(.ADDR_W(8), .DATA_W(8)) a ();
    ram_arb_ctrl_if #(.ADDR_W(8), .DATA_W(8)) b ();

    ram_arb_ctrl #(.ADDR_W(8), .DATA_W(8), .RD_LAT(1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(a.slave));
    ram_arb_ctrl #(.ADDR_W(8), .DATA_W(8), .RD_LAT(3)) dut_b (.clk(clk), .rst_n(rst_n), .bus(b.slave));

    // RAM models: read data appears RD_LAT cycles after the strobe, 0 otherwise.
    logic [7:0] mem_a [256];
    logic [7:0] mem_b [256];
    logic [7:0] sh_a [4];
    logic [7:0] sh_b [4];

    always @(posedge clk) begin
        if (a.ram_cs && a.ram_wr) mem_a[a.ram_addr] <= a.ram_wdata;
        sh_a[0] <= (a.ram_cs && a.ram_rd) ? mem_a[a.ram_addr] : 8'h00;
        for (int i = 1; i < 4; i++) sh_a[i] <= sh_a[i-1];
    end

    always @(posedge clk) begin
        if (b.ram_cs && b.ram_wr) mem_b[b.ram_addr] <= b.ram_wdata;
        sh_b[0] <= (b.ram_cs && b.ram_rd) ? mem_b[b.ram_addr] : 8'h00;
        for (int i = 1; i < 4; i++) sh_b[i] <= sh_b[i-1];
    end

    assign a.ram_rdata = sh_a[0];
    assign b.ram_rdata = sh_b[2];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    task automatic set_req(input int p, input logic v, input logic w, input logic [7:0] ad, input logic [7:0] wd);
        a.req_valid[p]        = v;
        a.req_wr[p]           = w;
        a.req_addr[p*8 +: 8]  = ad;
        a.req_wdata[p*8 +: 8] = wd;
        #1;
    endtask

    task automatic do_write(input int p, input logic [7:0] ad, input logic [7:0] wd);
        logic [1:0] e;
        e = (p == 1) ? 2'b10 : 2'b01;
        set_req(p, 1'b1, 1'b1, ad, wd);
        chk("wr_ready", a.req_ready, e);
        tick;
        chk("wr_strobe", a.ram_wr, 1'b1);
        chk("wr_addr", a.ram_addr, ad);
        chk("wr_data", a.ram_wdata, wd);
        set_req(p, 1'b0, 1'b0, 8'h00, 8'h00);
        tick;
        chk("wr_done", a.ram_wr, 1'b0);
    endtask

    task automatic do_read(input int p, input logic [7:0] ad, input logic [7:0] exp);
        logic [1:0] e;
        e = (p == 1) ? 2'b10 : 2'b01;
        set_req(p, 1'b1, 1'b0, ad, 8'h00);
        chk("rd_ready", a.req_ready, e);
        tick;
        chk("rd_strobe", a.ram_rd, 1'b1);
        chk("rd_addr", a.ram_addr, ad);
        set_req(p, 1'b0, 1'b0, 8'h00, 8'h00);
        tick;
        chk("rd_wait_rsp", a.rsp_valid, 2'b00);
        chk("rd_wait_strobe", a.ram_rd, 1'b0);
        tick;
        chk("rd_rsp", a.rsp_valid, e);
        chk("rd_data", a.rsp_rdata, exp);
        tick;
        chk("rd_rsp_end", a.rsp_valid, 2'b00);
    endtask

    initial begin
        a.req_valid = '0; a.req_wr = '0; a.req_addr = '0; a.req_wdata = '0;
        b.req_valid = '0; b.req_wr = '0; b.req_addr = '0; b.req_wdata = '0;
        tick;
        tick;
        chk("rst_ready", a.req_ready, 2'b00);
        chk("rst_cs", a.ram_cs, 1'b0);
        chk("rst_rsp", a.rsp_valid, 2'b00);
        chk("rst_rdata", a.rsp_rdata, 8'h00);
        chk("rst_addr", a.ram_addr, 8'h00);
        rst_n = 1'b1;
        tick;

        // Contention from reset: grants alternate 0,1,0,1.
        set_req(0, 1'b1, 1'b1, 8'h01, 8'h11);
        set_req(1, 1'b1, 1'b1, 8'h02, 8'h22);
        for (int i = 0; i < 8; i++) begin
            chk("rr_ready", a.req_ready, (i % 2) ? 2'b00 : ((i % 4 == 0) ? 2'b01 : 2'b10));
            if (i % 2) chk("rr_addr", a.ram_addr, (i % 4 == 1) ? 8'h01 : 8'h02);
            if (i == 7) begin
                set_req(0, 1'b0, 1'b0, 8'h00, 8'h00);
                set_req(1, 1'b0, 1'b0, 8'h00, 8'h00);
            end
            tick;
        end
        do_read(0, 8'h01, 8'h11);
        do_read(1, 8'h02, 8'h22);

        do_write(0, 8'h10, 8'hA5);
        do_read(0, 8'h10, 8'hA5);

        // Port1 back-to-back writes: ready every second cycle.
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) begin
                set_req(1, 1'b1, 1'b1, 8'h30 + 8'(i / 2), 8'h40 + 8'(i / 2));
                chk("b2b_ready", a.req_ready, 2'b10);
            end else begin
                chk("b2b_gap", a.req_ready, 2'b00);
                chk("b2b_wr", a.ram_wr, 1'b1);
                chk("b2b_addr", a.ram_addr, 8'h30 + 8'(i / 2));
            end
            if (i == 7) set_req(1, 1'b0, 1'b0, 8'h00, 8'h00);
            tick;
        end
        do_read(1, 8'h32, 8'h42);

        // RD_LAT=3 instance: response at M+5.
        b.req_valid = 2'b01; b.req_wr = 2'b01; b.req_addr = 16'h0007; b.req_wdata = 16'h003C;
        #1;
        chk("l3_wready", b.req_ready, 2'b01);
        tick;
        chk("l3_wr", b.ram_wr, 1'b1);
        b.req_valid = 2'b00;
        tick;
        b.req_valid = 2'b01; b.req_wr = 2'b00;
        #1;
        chk("l3_rready", b.req_ready, 2'b01);
        tick;
        chk("l3_rd_m1", b.ram_rd, 1'b1);
        b.req_valid = 2'b00;
        for (int i = 2; i <= 4; i++) begin
            tick;
            chk("l3_rd_once", b.ram_rd, 1'b0);
            chk("l3_no_rsp", b.rsp_valid, 2'b00);
        end
        tick;
        chk("l3_rsp", b.rsp_valid, 2'b01);
        chk("l3_data", b.rsp_rdata, 8'h3C);
        tick;
        chk("l3_rsp_end", b.rsp_valid, 2'b00);

        // Reset during WAIT of a port0 read; last winner was port0 beforehand.
        set_req(0, 1'b1, 1'b0, 8'h30, 8'h00);
        chk("ar_ready", a.req_ready, 2'b01);
        tick;
        set_req(0, 1'b0, 1'b0, 8'h00, 8'h00);
        tick;
        rst_n = 1'b0;
        #1;
        chk("ar_cs", a.ram_cs, 1'b0);
        chk("ar_rd", a.ram_rd, 1'b0);
        chk("ar_rsp", a.rsp_valid, 2'b00);
        chk("ar_rdata", a.rsp_rdata, 8'h00);
        chk("ar_addr", a.ram_addr, 8'h00);
        set_req(0, 1'b1, 1'b1, 8'h01, 8'h11);
        set_req(1, 1'b1, 1'b1, 8'h02, 8'h22);
        chk("ar_ready_rst", a.req_ready, 2'b00);
        tick;
        chk("ar_rsp_1", a.rsp_valid, 2'b00);
        tick;
        chk("ar_rsp_2", a.rsp_valid, 2'b00);
        rst_n = 1'b1;
        #1;
        chk("ar_first", a.req_ready, 2'b01);
        tick;
        chk("ar_issue_addr", a.ram_addr, 8'h01);
        chk("ar_rsp_3", a.rsp_valid, 2'b00);
        set_req(0, 1'b0, 1'b0, 8'h00, 8'h00);
        set_req(1, 1'b0, 1'b0, 8'h00, 8'h00);
        tick;
        chk("ar_rsp_4", a.rsp_valid, 2'b00);

        // Port0 waits while port1's read runs to completion.
        set_req(1, 1'b1, 1'b0, 8'h02, 8'h00);
        chk("hold_p1", a.req_ready, 2'b10);
        tick;
        set_req(1, 1'b0, 1'b0, 8'h00, 8'h00);
        set_req(0, 1'b1, 1'b1, 8'h05, 8'h55);
        chk("hold_issue", a.req_ready, 2'b00);
        tick;
        chk("hold_wait", a.req_ready, 2'b00);
        tick;
        chk("hold_resp", a.req_ready, 2'b00);
        chk("hold_rsp", a.rsp_valid, 2'b10);
        chk("hold_data", a.rsp_rdata, 8'h22);
        tick;
        chk("hold_grant", a.req_ready, 2'b01);
        tick;
        chk("hold_wr", a.ram_wr, 1'b1);
        chk("hold_addr", a.ram_addr, 8'h05);
        set_req(0, 1'b0, 1'b0, 8'h00, 8'h00);
        tick;
        do_read(0, 8'h05, 8'h55);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ram_arb_ctrl.md
Name: ram_arb_ctrl

Overview:
- Two-requester controller that shares the single-port synchronous RAM (cs/wr/rd/address/data_in/data_out) between two independent masters.
- Accepts one request at a time via valid/ready, issues exactly one RAM cycle, and returns read data with a one-cycle response pulse.
- Sits between bus-side masters and the RAM instance.
- Fairness is round-robin.

Parameters:
- ADDR_W, 8, RAM address width.
- DATA_W, 8, RAM data width.
- RD_LAT, 1, cycles from RAM read strobe to valid data_out; legal range 1..4.

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  2  per-port request valid; bit i = port i.
- req_ready  out  2  per-port request accept.
- req_wr  in  2  per-port 1 = write, 0 = read.
- req_addr  in  2*ADDR_W  per-port address; port i occupies slice [i*ADDR_W +: ADDR_W].
- req_wdata  in  2*DATA_W  per-port write data, sliced the same way.
- rsp_valid  out  2  per-port one-cycle read-data-valid pulse.
- rsp_rdata  out  DATA_W  read data; shared by both ports, qualified by rsp_valid.
- ram_cs  out  1  RAM chip select.
- ram_wr  out  1  RAM write strobe.
- ram_rd  out  1  RAM read strobe.
- ram_addr  out  ADDR_W  RAM address.
- ram_wdata  out  DATA_W  RAM data_in.
- ram_rdata  in  DATA_W  RAM data_out.

Behaviour:
- Clock and reset: clk is the only clock. rst_n is asynchronous and active-low.
- Reset values:
  - All outputs 0.
  - FSM in IDLE.
  - Round-robin pointer last_gnt = 1, so port 0 wins the first contention.
  - Latched address/data/wr/port registers 0.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Grant decision is combinational in this state only.
  - One valid port: that port is granted.
  - Both ports valid: the port != last_gnt is granted.
  - req_ready[g] = 1 for the granted port only. req_ready is 0 in every other state.
  - On the handshake (valid & ready): latch addr, wdata, wr and the port id; set last_gnt = g; go to ISSUE.
  - No valid request: stay in IDLE.
- ISSUE (exactly one cycle):
  - ram_cs = 1 and ram_addr = latched addr.
  - Write: ram_wr = 1, ram_wdata = latched wdata; next state IDLE.
  - Read: ram_rd = 1; load the latency counter with RD_LAT; next state WAIT.
  - ram_cs, ram_wr and ram_rd are 0 in all other states. ram_addr and ram_wdata hold their last values.
- WAIT:
  - Counter decrements each cycle.
  - When the counter reaches 1, capture ram_rdata into rsp_rdata at that clock edge and go to RESP.
  - Capture therefore happens at the end of cycle ISSUE+RD_LAT.
- RESP:
  - rsp_valid[port] = 1 for exactly one cycle; next state IDLE.
  - rsp_rdata holds its value until the next read capture.
  - Responses have no backpressure; masters must accept them.
- Timing, with request accepted in cycle N:
  - RAM strobe in N+1.
  - Write completes in N+1; the next grant is possible in N+2.
  - Read response in N+2+RD_LAT; the next grant is possible in N+3+RD_LAT.
- Masters must hold req_* stable while valid && !ready. The block does not check this.
- A port still holding valid after being serviced competes again in the next IDLE cycle. Round-robin then guarantees alternation under continuous contention.
- Reset asserted mid-operation (any state): immediate return to reset values. Any in-flight read produces no rsp_valid. A write strobe already sampled by the RAM is not undone.
- Width rules: no arithmetic on addresses. The counter is $clog2(RD_LAT+1) bits wide.

Decomposition:
- Package ram_arb_pkg contains:
  - enum state_t {IDLE, ISSUE, WAIT, RESP}, 2-bit.
  - typedef port_id_t, 1-bit.
  - localparam NUM_PORTS = 2.
- Sub-module ram_rr_arbiter contains:
  - the last_gnt register;
  - the combinational grant / req_ready logic;
  - an update enable driven by the handshake.
- The FSM, datapath latches and latency counter stay in ram_arb_ctrl.

Test Plan:
- Port0 write addr 0x10 data 0xA5, then port0 read 0x10 (RD_LAT=1):
  - ram_wr is high in cycle N+1.
  - rsp_valid[0] pulses exactly at cycle M+3, where M is the read-accept cycle, with rsp_rdata = 0xA5.
- Both ports valid from reset:
  - port0 writes 0x01 -> 0x11 and port1 writes 0x02 -> 0x22.
  - Grant order is 0,1,0,1 with no starvation while both stay valid.
  - Reading back returns 0x11 and 0x22.
- Port1 alone issues 4 back-to-back writes:
  - req_ready[1] pulses every 2 cycles.
  - req_ready[0] stays 0.
- RD_LAT=3 build, port0 read:
  - ram_rd is high for exactly one cycle.
  - rsp_valid[0] asserts at M+5, with data sampled from ram_rdata at the end of cycle M+4.
- rst_n dropped during WAIT of a read:
  - All outputs go to 0 asynchronously; rsp_valid never fires.
  - After release, port0 wins first contention.
- Port0 valid held while port1's read is in progress:
  - req_ready[0] = 0 until port1's RESP completes.
  - Port0 is accepted in the following IDLE cycle.
